// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: FSM states, ALU widths and opcodes shared by the scheduler and ALU
package alu_sched_pkg;
  localparam int DW = 8;
  localparam int OPW = 4;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;
  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_AND = 4'd2;
  localparam logic [OPW-1:0] OP_OR  = 4'd3;
  localparam logic [OPW-1:0] OP_XOR = 4'd4;
endpackage

// File: rtl/alu_8.sv
// ALU_8: 8-bit combinational ALU with zero/negative/signed-overflow flags
module ALU_8
  import alu_sched_pkg::*;
(
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  result,
  output logic           zero,
  output logic           negative,
  output logic           overflow
);
  // unknown opcodes pass operand A through and never flag overflow
  always_comb begin
    result   = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? a & b :
               op == OP_OR ? a | b : op == OP_XOR ? a ^ b : a;
    overflow = op == OP_ADD ? (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]) :
               op == OP_SUB ? (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]) : 1'b0;
    zero     = result == '0;
    negative = result[DW-1];
  end
endmodule

// File: rtl/alu_8_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first valid at or after ptr with wrap
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  // scan offsets from farthest to nearest so the nearest valid requester wins
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (valid[j]) idx = j;
    end
    any = |valid;
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_8_sched.sv
// alu_8_sched: round-robin sharing of one ALU_8 among NUM_REQ requesters; ALU_SCHED_OVF_TRAP_EN adds sticky OvfTrap/TrapClear
module alu_8_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     ReqValid,
  output logic [NUM_REQ-1:0]     ReqReady,
  input  logic [NUM_REQ*DW-1:0]  ReqA,
  input  logic [NUM_REQ*DW-1:0]  ReqB,
  input  logic [NUM_REQ*OPW-1:0] ReqAluOp,
  output logic [NUM_REQ-1:0]     RspValid,
  input  logic [NUM_REQ-1:0]     RspReady,
  output logic [DW-1:0]          RspResult,
  output logic                   RspZero,
  output logic                   RspNegative,
  output logic                   RspOverflow
`ifdef ALU_SCHED_OVF_TRAP_EN
  ,
  output logic                   OvfTrap,
  input  logic                   TrapClear
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state;
  logic [IW-1:0] ptr, gnt_id, win_id;
  logic [NUM_REQ-1:0] win;
  logic any;
  logic [DW-1:0] a_arr [NUM_REQ];
  logic [DW-1:0] b_arr [NUM_REQ];
  logic [OPW-1:0] op_arr [NUM_REQ];
  logic [DW-1:0] a_q, b_q, alu_res;
  logic [OPW-1:0] op_q;
  logic alu_z, alu_n, alu_v;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]  = ReqA[DW*i +: DW];
    assign b_arr[i]  = ReqB[DW*i +: DW];
    assign op_arr[i] = ReqAluOp[OPW*i +: OPW];
  end
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .valid(ReqValid),
    .ptr  (ptr),
    .gnt  (win),
    .idx  (win_id),
    .any  (any)
  );
  ALU_8 u_alu (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .result  (alu_res),
    .zero    (alu_z),
    .negative(alu_n),
    .overflow(alu_v)
  );
  assign ReqReady = state == S_IDLE ? win : '0;
  assign RspValid = state == S_RESP ? NUM_REQ'(1) << gnt_id : '0;
  // accept -> execute -> respond; ptr advances only when the winner takes its response
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      gnt_id      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      RspResult   <= '0;
      RspZero     <= 1'b0;
      RspNegative <= 1'b0;
      RspOverflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (any) begin
          a_q    <= a_arr[win_id];
          b_q    <= b_arr[win_id];
          op_q   <= op_arr[win_id];
          gnt_id <= win_id;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          RspResult   <= alu_res;
          RspZero     <= alu_z;
          RspNegative <= alu_n;
          RspOverflow <= alu_v;
          state       <= S_RESP;
        end
        S_RESP: if (RspReady[gnt_id]) begin
          ptr   <= gnt_id == IW'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef ALU_SCHED_OVF_TRAP_EN
  // sticky overflow trap; a set in the same cycle beats TrapClear
  always_ff @(posedge Clk) begin
    if (Reset) OvfTrap <= 1'b0;
    else if (state == S_EXEC && alu_v) OvfTrap <= 1'b1;
    else if (TrapClear) OvfTrap <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_alu_8_sched.sv
// tb_alu_8_sched: table vectors, hand sequences and random ops against an arithmetic reference model
module tb_alu_8_sched;
  import alu_sched_pkg::*;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [3:0] ReqValid = '0, ReqReady, RspValid, RspReady = '0;
  logic [31:0] ReqA, ReqB;
  logic [15:0] ReqAluOp;
  logic [7:0] RspResult;
  logic RspZero, RspNegative, RspOverflow;
`ifdef ALU_SCHED_OVF_TRAP_EN
  logic OvfTrap;
  logic TrapClear = 1'b0;
`endif
  logic [7:0] a_v [4];
  logic [7:0] b_v [4];
  logic [3:0] op_v [4];
  int errors = 0, checks = 0, ptr_m = 0;

  typedef struct {
    int id;
    logic [7:0] a, b;
    logic [3:0] op;
    logic [7:0] res;
    logic z, n, v;
  } vec_t;
  vec_t vecs [8];

  always #5 Clk = ~Clk;

  always_comb begin
    ReqA = '0;
    ReqB = '0;
    ReqAluOp = '0;
    for (int i = 0; i < 4; i++) begin
      ReqA[8*i +: 8] = a_v[i];
      ReqB[8*i +: 8] = b_v[i];
      ReqAluOp[4*i +: 4] = op_v[i];
    end
  end

  alu_8_sched #(.NUM_REQ(4)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA(ReqA), .ReqB(ReqB), .ReqAluOp(ReqAluOp), .RspValid(RspValid),
    .RspReady(RspReady), .RspResult(RspResult), .RspZero(RspZero),
    .RspNegative(RspNegative), .RspOverflow(RspOverflow)
`ifdef ALU_SCHED_OVF_TRAP_EN
    , .OvfTrap(OvfTrap), .TrapClear(TrapClear)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] m);
    logic [1:0] j;
    for (int k = 0; k < 4; k++) begin
      j = 2'((ptr_m + k) % 4);
      if (m[j]) return int'(j);
    end
    return 0;
  endfunction

  task automatic ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic z, output logic n, output logic v);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v = 1'b0;
    if (op == OP_ADD || op == OP_SUB) begin
      s = op == OP_ADD ? sa + sb : sa - sb;
      v = s > 127 || s < -128;
      r = 8'(s);
    end else if (op == OP_AND) r = a & b;
    else if (op == OP_OR) r = a | b;
    else if (op == OP_XOR) r = a ^ b;
    else r = a;
    z = r == 8'h00;
    n = r[7];
  endtask

  task automatic run_op(input logic [3:0] mask, input int stall, input logic [7:0] er,
                        input logic ez, input logic en, input logic ev);
    logic [3:0] oh;
    int w;
    w = pick(mask);
    oh = 4'(1 << w);
    ReqValid = mask;
    RspReady = stall > 0 ? ~oh : 4'hF;
    @(negedge Clk);
    chk("accept_ready", 32'(ReqReady), 32'(oh));
    chk("accept_rspvalid", 32'(RspValid), 0);
    @(posedge Clk);
    #1 ReqValid = mask & ~oh;
    @(negedge Clk);
    chk("exec_ready", 32'(ReqReady), 0);
    chk("exec_rspvalid", 32'(RspValid), 0);
    @(negedge Clk);
    chk("rsp_valid", 32'(RspValid), 32'(oh));
    chk("rsp_result", 32'(RspResult), 32'(er));
    chk("rsp_zero", 32'(RspZero), 32'(ez));
    chk("rsp_negative", 32'(RspNegative), 32'(en));
    chk("rsp_overflow", 32'(RspOverflow), 32'(ev));
    chk("rsp_ready", 32'(ReqReady), 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge Clk);
      chk("hold_valid", 32'(RspValid), 32'(oh));
      chk("hold_result", 32'(RspResult), 32'(er));
      chk("hold_ready", 32'(ReqReady), 0);
    end
    RspReady = 4'hF;
    @(posedge Clk);
    #1 ReqValid = '0;
    ptr_m = (w + 1) % 4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] er;
    logic ez, en, ev;
    logic [3:0] mask;
    int w;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 8'($urandom);
      b_v[i] = 8'($urandom);
      op_v[i] = OP_ADD;
    end
    vecs[0] = '{2, 8'h05, 8'h03, OP_ADD, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{3, 8'h33, 8'h33, OP_SUB, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h80, 8'h01, OP_SUB, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{2, 8'hF0, 8'h0F, OP_AND, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1, 8'hF0, 8'h0F, OP_OR,  8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{0, 8'hAA, 8'hFF, OP_XOR, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3, 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_reqready", 32'(ReqReady), 0);
    chk("reset_rspvalid", 32'(RspValid), 0);
    chk("reset_result", 32'(RspResult), 0);
    chk("reset_flags", 32'({RspZero, RspNegative, RspOverflow}), 0);
`ifdef ALU_SCHED_OVF_TRAP_EN
    chk("reset_trap", 32'(OvfTrap), 0);
`endif
    @(posedge Clk);
    #1 Reset = 1'b0;

    ReqValid = 4'hF;
    RspReady = 4'hF;
    for (int c = 0; c < 15; c++) begin
      @(negedge Clk);
      chk("rr_grant", 32'(ReqReady), c % 3 == 0 ? 32'(1 << ((c / 3) % 4)) : 0);
      @(posedge Clk);
      #1;
    end
    ReqValid = '0;
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    ptr_m = 0;

    for (int i = 0; i < 8; i++) begin
      a_v[vecs[i].id] = vecs[i].a;
      b_v[vecs[i].id] = vecs[i].b;
      op_v[vecs[i].id] = vecs[i].op;
      run_op(4'(1 << vecs[i].id), 0, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].v);
    end
`ifdef ALU_SCHED_OVF_TRAP_EN
    @(negedge Clk);
    chk("trap_sticky", 32'(OvfTrap), 1);
    TrapClear = 1'b1;
    @(posedge Clk);
    #1 TrapClear = 1'b0;
    @(negedge Clk);
    chk("trap_cleared", 32'(OvfTrap), 0);
    @(posedge Clk);
    #1;
`endif

    for (int i = 0; i < 4; i++) begin
      a_v[i] = 8'h12;
      b_v[i] = 8'h34;
      op_v[i] = OP_ADD;
    end
    run_op(4'b1001, 5, 8'h46, 1'b0, 1'b0, 1'b0);

    ReqValid = 4'b0010;
    @(negedge Clk);
    chk("midrst_accept", 32'(ReqReady), 32'(4'b0010));
    @(posedge Clk);
    #1 ReqValid = '0;
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    ptr_m = 0;
    @(negedge Clk);
    chk("midrst_result", 32'(RspResult), 0);
    chk("midrst_flags", 32'({RspZero, RspNegative, RspOverflow}), 0);
    for (int c = 0; c < 3; c++) begin
      chk("midrst_rspvalid", 32'(RspValid), 0);
      chk("midrst_reqready", 32'(ReqReady), 0);
      @(negedge Clk);
    end
    @(posedge Clk);
    #1;

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        a_v[i] = 8'($urandom);
        b_v[i] = 8'($urandom);
        op_v[i] = 4'($urandom_range(0, 5));
      end
      mask = 4'($urandom_range(1, 15));
      w = pick(mask);
      ref_alu(op_v[w], a_v[w], b_v[w], er, ez, en, ev);
      run_op(mask, int'($urandom_range(0, 3)), er, ez, en, ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
